// File: rtl/vc_test_arb_pkg.sv
// Shared definitions for the test-sink arbiter: FSM state encoding and
// the helper that sizes the requester tag.
package vc_test_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Tag width for a given requester count; never narrower than one bit.
  function automatic int tag_width(input int num_reqs);
    return (num_reqs <= 2) ? 1 : $clog2(num_reqs);
  endfunction

endpackage

// File: rtl/vc_rr_arb.sv
// Combinational round-robin picker: grants the first requester at or above
// ptr that is requesting, wrapping from the top index back to zero.
module vc_rr_arb
  import vc_test_arb_pkg::*;
#(
  parameter int p_num_reqs  = 4,
  parameter int p_tag_nbits = tag_width(p_num_reqs)
) (
  input  logic [p_num_reqs-1:0]  req,
  input  logic [p_tag_nbits-1:0] ptr,
  output logic [p_num_reqs-1:0]  grant,
  output logic [p_tag_nbits-1:0] idx,
  output logic                   any
);

  // Scan from ptr upward with wrap; the first requesting slot wins.
  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < p_num_reqs; k++) begin
      j = int'(ptr) + k;
      if (j >= p_num_reqs) j = j - p_num_reqs;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = p_tag_nbits'(j);
      end
    end
  end

endmodule

// File: rtl/vc_test_sink_arbiter.sv
// Funnels several valid/ready requesters into one shared test sink through a
// single output register, tagging each message with its source index, and
// raises a sticky done once a programmed number of messages has been drained.
module vc_test_sink_arbiter
  import vc_test_arb_pkg::*;
#(
  parameter int p_msg_nbits = 64,
  parameter int p_num_reqs  = 4,
  parameter int p_tag_nbits = tag_width(p_num_reqs)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                go,
  input  logic [31:0]                         total_msgs,
  input  logic [p_num_reqs-1:0]               in_val,
  output logic [p_num_reqs-1:0]               in_rdy,
  input  logic [p_num_reqs*p_msg_nbits-1:0]   in_msg,
  output logic                                out_val,
  input  logic                                out_rdy,
  output logic [p_tag_nbits+p_msg_nbits-1:0]  out_msg,
  output logic                                done
);

  localparam logic [p_tag_nbits-1:0] last_idx = p_tag_nbits'(p_num_reqs - 1);

  state_e                           state_reg, state_next;
  logic [p_tag_nbits-1:0]           ptr_reg;
  logic [31:0]                      total_reg;
  logic [31:0]                      accepted_reg;
  logic [31:0]                      delivered_reg;
  logic                             out_val_reg;
  logic [p_tag_nbits+p_msg_nbits-1:0] out_msg_reg;
  logic                             done_reg;

  logic [p_num_reqs-1:0]            grant;
  logic [p_tag_nbits-1:0]           pick_idx;
  logic                             pick_any;
  logic                             free;
  logic                             can_accept;
  logic                             in_xfer;
  logic                             out_xfer;
  logic [p_msg_nbits-1:0]           payload [p_num_reqs];

  // Unpack the flat payload bus into one word per requester.
  for (genvar gi = 0; gi < p_num_reqs; gi++) begin : g_payload
    assign payload[gi] = in_msg[gi*p_msg_nbits +: p_msg_nbits];
  end

  vc_rr_arb #(
    .p_num_reqs  (p_num_reqs),
    .p_tag_nbits (p_tag_nbits)
  ) u_rr_arb (
    .req   (in_val),
    .ptr   (ptr_reg),
    .grant (grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // The output register can take a new message when empty or draining now;
  // acceptance also stops once the programmed count has been taken in.
  assign free       = !out_val_reg || out_rdy;
  assign can_accept = (state_reg == ST_RUN) && free && (accepted_reg != total_reg);
  assign in_rdy     = can_accept ? grant : '0;
  assign in_xfer    = can_accept && pick_any;
  assign out_xfer   = out_val_reg && out_rdy;

  // Next-state logic: start on go, finish once everything has been drained.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (go) state_next = ST_RUN;
      ST_RUN:  if (delivered_reg == total_reg) state_next = ST_DONE;
      ST_DONE: state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State, done flag and message counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      done_reg      <= 1'b0;
      total_reg     <= '0;
      accepted_reg  <= '0;
      delivered_reg <= '0;
    end else begin
      state_reg <= state_next;
      done_reg  <= (state_next == ST_DONE);
      if (state_reg == ST_IDLE && go) begin
        total_reg     <= total_msgs;
        accepted_reg  <= '0;
        delivered_reg <= '0;
      end else begin
        if (in_xfer)  accepted_reg  <= accepted_reg + 32'd1;
        if (out_xfer) delivered_reg <= delivered_reg + 32'd1;
      end
    end
  end

  // Output register and round-robin pointer; the pointer moves only when a
  // message is actually taken from a requester.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_val_reg <= 1'b0;
      out_msg_reg <= '0;
      ptr_reg     <= '0;
    end else if (in_xfer) begin
      out_val_reg <= 1'b1;
      out_msg_reg <= {pick_idx, payload[pick_idx]};
      ptr_reg     <= (pick_idx == last_idx) ? '0 : pick_idx + 1'b1;
    end else if (out_rdy) begin
      out_val_reg <= 1'b0;
    end
  end

  assign out_val = out_val_reg;
  assign out_msg = out_msg_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_vc_test_sink_arbiter.sv
// Bench for vc_test_sink_arbiter: a cycle-level behavioural model checked on
// every falling edge, plus directed scenarios with literal expectations.
module tb_vc_test_sink_arbiter;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int T  = 2;
  localparam int MW = T + W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          go = 1'b0;
  logic [31:0]   total_msgs = '0;
  logic [N-1:0]  in_val = '0;
  logic [N-1:0]  in_rdy;
  logic [N*W-1:0] in_msg = '0;
  logic          out_val;
  logic          out_rdy = 1'b0;
  logic [MW-1:0] out_msg;
  logic          done;

  always #5 clk = ~clk;

  vc_test_sink_arbiter #(.p_msg_nbits(W), .p_num_reqs(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .total_msgs (total_msgs),
    .in_val     (in_val),
    .in_rdy     (in_rdy),
    .in_msg     (in_msg),
    .out_val    (out_val),
    .out_rdy    (out_rdy),
    .out_msg    (out_msg),
    .done       (done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  bit            m_armed = 0;
  int            m_phase;          // 0 idle, 1 run, 2 done
  int            m_ptr, m_acc, m_del, m_total;
  bit            m_vld, m_done;
  logic [MW-1:0] m_msg;

  // Observations for directed checks
  logic [MW-1:0] obs[$];
  int            obs_cyc[$];
  int            cyc = 0;
  int            rdy_cycles = 0;
  logic [N-1:0]  acc_mask = '0;
  int            seq [N];

  // Compare DUT against the model, then advance the model by one clock.
  always @(negedge clk) begin
    logic [N-1:0] e_rdy;
    int pick, j, nphase;
    bit e_free;
    e_rdy = '0;
    pick  = -1;
    cyc++;
    if (m_armed) begin
      e_free = !m_vld || out_rdy;
      if (m_phase == 1 && e_free && m_acc != m_total) begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (pick < 0 && in_val[j]) pick = j;
        end
      end
      if (pick >= 0) e_rdy[pick] = 1'b1;
      check("in_rdy",  in_rdy,  e_rdy);
      check("out_val", out_val, m_vld);
      check("out_msg", out_msg, m_msg);
      check("done",    done,    m_done);
    end
    acc_mask = in_rdy & in_val;
    if (|in_rdy) rdy_cycles++;
    if (out_val && out_rdy) begin
      obs.push_back(out_msg);
      obs_cyc.push_back(cyc);
    end
    if (reset) begin
      m_armed = 1; m_phase = 0; m_ptr = 0; m_acc = 0; m_del = 0; m_total = 0;
      m_vld = 0; m_msg = '0; m_done = 0;
    end else if (m_armed) begin
      nphase = m_phase;
      if (m_phase == 0 && go) begin
        nphase = 1; m_total = int'(total_msgs); m_acc = 0; m_del = 0;
      end else if (m_phase == 1 && m_del == m_total) begin
        nphase = 2;
      end
      if (m_vld && out_rdy) m_del++;
      if (pick >= 0) begin
        m_msg = {T'(pick), in_msg[pick*W +: W]};
        m_vld = 1;
        m_ptr = (pick + 1) % N;
        m_acc++;
      end else if (out_rdy) begin
        m_vld = 0;
      end
      m_phase = nphase;
      m_done  = (nphase == 2);
    end
  end

  // Payload of requester i: marker byte A0+i and its own sequence number.
  task automatic set_msgs();
    for (int i = 0; i < N; i++)
      in_msg[i*W +: W] = {8'(8'hA0 + i), 24'h0, 32'(seq[i])};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc_mask[i]) seq[i]++;
    set_msgs();
  endtask

  task automatic do_reset();
    reset = 1'b1; go = 1'b0; in_val = '0; out_rdy = 1'b0;
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < N; i++) seq[i] = 0;
    set_msgs();
    obs.delete(); obs_cyc.delete();
  endtask

  task automatic start(input int total);
    total_msgs = 32'(total); go = 1'b1;
    step();
    go = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int c = 0; c < budget && !done; c++) step();
    check("done_reached", done, 1'b1);
  endtask

  task automatic check_tags(input string name, input int exp_tags[$]);
    check({name, "_count"}, obs.size(), exp_tags.size());
    for (int k = 0; k < exp_tags.size() && k < obs.size(); k++) begin
      check({name, "_tag"}, obs[k][MW-1 -: T], exp_tags[k]);
      check({name, "_cycle"}, obs_cyc[k] - obs_cyc[0], k);
    end
  endtask

  int next_seq [N];
  int t;

  initial begin
    // Reset state
    do_reset();
    check("rst_out_val", out_val, 1'b0);
    check("rst_out_msg", out_msg, '0);
    check("rst_done", done, 1'b0);
    check("rst_in_rdy", in_rdy, '0);

    // Round robin with all requesters valid
    in_val = 4'b1111; out_rdy = 1'b1;
    start(8);
    wait_done(50);
    check_tags("rr_all", '{0, 1, 2, 3, 0, 1, 2, 3});

    // Idle requesters are skipped
    do_reset();
    in_val = 4'b1010; out_rdy = 1'b1;
    start(4);
    wait_done(50);
    check_tags("rr_skip", '{1, 3, 1, 3});

    // Backpressure holds the single buffered message
    do_reset();
    in_val = 4'b1111; out_rdy = 1'b0;
    start(2);
    step();
    for (int c = 0; c < 5; c++) begin
      check("bp_out_val", out_val, 1'b1);
      check("bp_out_msg", out_msg, {2'd0, 8'hA0, 24'h0, 32'd0});
      check("bp_in_rdy", in_rdy, '0);
      step();
    end
    check("bp_no_delivery", obs.size(), 0);
    out_rdy = 1'b1;
    step();
    check("bp_one_delivery", obs.size(), 1);
    wait_done(20);
    check("bp_total", obs.size(), 2);

    // total_msgs = 0: done two cycles after go, never any in_rdy
    do_reset();
    in_val = 4'b1111; out_rdy = 1'b1;
    rdy_cycles = 0;
    start(0);
    check("zero_done_c1", done, 1'b0);
    step();
    check("zero_done_c2", done, 1'b1);
    go = 1'b1; step(); go = 1'b0; step();
    check("zero_done_sticky", done, 1'b1);
    check("zero_no_rdy", rdy_cycles, 0);

    // total_msgs = 3 with four valid requesters: exactly three accepted
    do_reset();
    in_val = 4'b1111; out_rdy = 1'b1;
    start(3);
    wait_done(50);
    step(); step();
    check_tags("three", '{0, 1, 2});

    // Reset mid-run discards the buffered message; restart begins at tag 0
    do_reset();
    in_val = 4'b1111; out_rdy = 1'b0;
    start(10);
    step(); step();
    check("midrst_pre_val", out_val, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_out_val", out_val, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_in_rdy", in_rdy, '0);
    obs.delete(); obs_cyc.delete();
    out_rdy = 1'b1;
    start(4);
    wait_done(50);
    check_tags("restart", '{0, 1, 2, 3});

    // Random traffic and sink backpressure, 200 messages
    do_reset();
    for (int i = 0; i < N; i++) next_seq[i] = 0;
    in_val = 4'($urandom); out_rdy = 1'($urandom_range(0, 1));
    start(200);
    for (int c = 0; c < 5000 && !done; c++) begin
      in_val  = 4'($urandom);
      out_rdy = 1'($urandom_range(0, 1));
      step();
    end
    check("rand_done", done, 1'b1);
    check("rand_count", obs.size(), 200);
    foreach (obs[k]) begin
      t = int'(obs[k][MW-1 -: T]);
      check("rand_marker", obs[k][W-1 -: 8], 8'(8'hA0 + t));
      check("rand_order", obs[k][31:0], next_seq[t]);
      next_seq[t]++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
